// File: rtl/nn_pkg.sv
// Shared types and sizing constants for the neural-network inference sequencer.
package nn_pkg;

    localparam int N_OUT       = 10;   // output neurons (result classes)
    localparam int WPN         = 392;  // weight words per neuron, two weights per word
    localparam int PIX_WORDS   = 196;  // pixel words per SRAM, four pixels per address
    localparam int ACC_W       = 36;   // signed accumulator width
    localparam int WEIGHT_BASE = 0;    // weight SRAM address of neuron 0, word 0

    localparam int K_W  = 9;           // word counter width (0..WPN)
    localparam int N_W  = 4;           // neuron counter width (0..N_OUT)
    localparam int WA_W = 12;          // weight SRAM address width
    localparam int PA_W = 10;          // pixel SRAM address width

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CMP,
        DONE
    } seq_state_t;

endpackage

// File: rtl/nn_mac2.sv
// Combinational two-term multiply-add: signed 16-bit weights times unsigned
// 8-bit pixels, summed and sign-extended to the accumulator width.
import nn_pkg::*;

module nn_mac2 (
    input  logic [15:0]      i_w_lo,
    input  logic [15:0]      i_w_hi,
    input  logic [7:0]       i_px_lo,
    input  logic [7:0]       i_px_hi,
    output logic [ACC_W-1:0] o_sum
);

    logic signed [24:0] w_p_lo;
    logic signed [24:0] w_p_hi;
    logic signed [25:0] w_sum;

    // Both operands are widened to 25 bits explicitly so the pixel stays
    // non-negative and the weight keeps its sign through the multiply.
    assign w_p_lo = $signed({{9{i_w_lo[15]}}, i_w_lo}) * $signed({17'b0, i_px_lo});
    assign w_p_hi = $signed({{9{i_w_hi[15]}}, i_w_hi}) * $signed({17'b0, i_px_hi});
    assign w_sum  = {w_p_lo[24], w_p_lo} + {w_p_hi[24], w_p_hi};
    assign o_sum  = {{(ACC_W-26){w_sum[25]}}, w_sum};

endmodule

// File: rtl/nn_inference_sequencer.sv
// Inference sequencer: owns the weight/pixel SRAMs while running, computes one
// 784-term dot product per output neuron and reports the argmax neuron.
import nn_pkg::*;

module nn_inference_sequencer (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result,
    output logic [ACC_W-1:0] max_score,
    output logic             r_enable,
    output logic [11:0]      weight_address,
    input  logic [31:0]      weight_value,
    output logic [9:0]       pixel_address,
    input  logic [15:0]      pixel_value1,
    input  logic [15:0]      pixel_value2
);

    localparam logic [K_W-1:0]  LAST_K    = K_W'(WPN - 1);
    localparam logic [N_W-1:0]  LAST_N    = N_W'(N_OUT - 1);
    localparam logic [WA_W-1:0] WPN_ADDR  = WA_W'(WPN);
    localparam logic [WA_W-1:0] BASE_ADDR = WA_W'(WEIGHT_BASE);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    seq_state_t                r_state;
    seq_state_t                w_next_state;
    logic [K_W-1:0]            r_k;
    logic [N_W-1:0]            r_n;
    logic [WA_W-1:0]           r_wbase;
    logic signed [ACC_W-1:0]   r_acc;
    logic [3:0]                r_best;
    logic signed [ACC_W-1:0]   r_bestv;

    logic                      w_odd_word;
    logic [7:0]                w_px [2];
    logic signed [ACC_W-1:0]   w_product;
    logic                      w_acc_en;

    // The data on the SRAM outputs belongs to word k-1; its parity picks
    // which pixel SRAM supplies the pixel pair.
    assign w_odd_word = ~r_k[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign w_px[gi] = w_odd_word ? pixel_value2[gi*8 +: 8] : pixel_value1[gi*8 +: 8];
    end

    nn_mac2 u_mac (
        .i_w_lo  (weight_value[15:0]),
        .i_w_hi  (weight_value[31:16]),
        .i_px_lo (w_px[0]),
        .i_px_hi (w_px[1]),
        .o_sum   (w_product)
    );

    // Accumulate once read data is valid: every ISSUE cycle after the first,
    // plus the DRAIN cycle that collects the last word.
    assign w_acc_en = ((r_state == ISSUE) && (r_k != '0)) || (r_state == DRAIN);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs; clear overrides everything.
    always_comb begin
        w_next_state   = r_state;
        busy           = 1'b0;
        done           = 1'b0;
        result         = '0;
        max_score      = '0;
        r_enable       = 1'b0;
        weight_address = '0;
        pixel_address  = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = ISSUE;
            end
            ISSUE: begin
                busy           = 1'b1;
                r_enable       = 1'b1;
                weight_address = r_wbase + {3'b0, r_k};
                pixel_address  = {2'b0, r_k[K_W-1:1]};
                if (r_k == LAST_K) w_next_state = DRAIN;
            end
            DRAIN: begin
                busy         = 1'b1;
                w_next_state = CMP;
            end
            CMP: begin
                busy         = 1'b1;
                w_next_state = (r_n == LAST_N) ? DONE : ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                result    = r_best;
                max_score = r_bestv;
                if (start) w_next_state = ISSUE;
            end
            default: w_next_state = IDLE;
        endcase
        if (clear) w_next_state = IDLE;
    end

    // Counters, accumulator and running argmax.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k     <= '0;
            r_n     <= '0;
            r_wbase <= BASE_ADDR;
            r_acc   <= '0;
            r_best  <= '0;
            r_bestv <= '0;
        end else if (clear) begin
            r_k     <= '0;
            r_n     <= '0;
            r_wbase <= BASE_ADDR;
            r_acc   <= '0;
            r_best  <= '0;
            r_bestv <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_k     <= '0;
                        r_n     <= '0;
                        r_wbase <= BASE_ADDR;
                        r_acc   <= '0;
                        r_best  <= '0;
                        r_bestv <= ACC_MIN;
                    end
                end
                ISSUE: begin
                    r_k <= r_k + 1'b1;
                    if (w_acc_en) r_acc <= r_acc + w_product;
                end
                DRAIN: begin
                    r_acc <= r_acc + w_product;
                end
                CMP: begin
                    // Strict compare so an equal later score keeps the lower index.
                    if (r_acc > r_bestv) begin
                        r_bestv <= r_acc;
                        r_best  <= r_n;
                    end
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_n     <= r_n + 1'b1;
                    r_wbase <= r_wbase + WPN_ADDR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: SRAM models, directed runs, scoreboard monitor.
module tb_nn_inference_sequencer;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               clear = 1'b0;
    logic               busy;
    logic               done;
    logic [3:0]         result;
    logic signed [35:0] max_score;
    logic               r_enable;
    logic [11:0]        weight_address;
    logic [31:0]        weight_value = '0;
    logic [9:0]         pixel_address;
    logic [15:0]        pixel_value1 = '0;
    logic [15:0]        pixel_value2 = '0;

    logic [31:0] wmem [4096];
    logic [15:0] pmem1 [1024];
    logic [15:0] pmem2 [1024];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]         res;
        logic signed [35:0] score;
        int                 cyc;
    } exp_t;
    exp_t exp_q[$];

    localparam int LATENCY = 3941;

    nn_inference_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .clear          (clear),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .max_score      (max_score),
        .r_enable       (r_enable),
        .weight_address (weight_address),
        .weight_value   (weight_value),
        .pixel_address  (pixel_address),
        .pixel_value1   (pixel_value1),
        .pixel_value2   (pixel_value2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM models: data valid one cycle after the address.
    always @(posedge clk) begin
        if (r_enable) begin
            weight_value <= wmem[weight_address];
            pixel_value1 <= pmem1[pixel_address];
            pixel_value2 <= pmem2[pixel_address];
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_weights();
        for (int i = 0; i < 4096; i++) wmem[i] = '0;
    endtask

    task automatic fill_neuron(input int n, input logic [31:0] even_w, input logic [31:0] odd_w);
        for (int j = 0; j < 392; j++) wmem[n*392 + j] = (j % 2 == 1) ? odd_w : even_w;
    endtask

    task automatic fill_pixels(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        for (int p = 0; p < 1024; p++) begin
            pmem1[p] = {b1, b0};
            pmem2[p] = {b3, b2};
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that samples start.
    task automatic do_start(input bit push, input logic [3:0] er, input logic signed [35:0] es,
                            output int c0);
        exp_t e;
        c0 = cyc;
        if (push) begin
            e.res   = er;
            e.score = es;
            e.cyc   = cyc + LATENCY;
            exp_q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: each rising edge of done pops one expected result.
    initial begin
        bit   done_q = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done && !done_q) begin
                $display("done: result=%0d max_score=%0d cycle=%0d", result, max_score, cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("max_score", max_score, e.score);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", busy, 0);
                end
            end
            done_q = done;
        end
    end

    initial begin
        int c0;

        clear_weights();
        fill_pixels(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_max_score", max_score, 0);
        chk("rst_r_enable", r_enable, 0);
        chk("rst_weight_address", weight_address, 0);
        chk("rst_pixel_address", pixel_address, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero weights, arbitrary pixels.
        for (int p = 0; p < 1024; p++) begin
            pmem1[p] = 16'($urandom);
            pmem2[p] = 16'($urandom);
        end
        do_start(1, 4'd0, 36'sd0, c0);
        chk("busy_after_start", busy, 1);
        wait_done();

        // Neuron 7 all +1, pixels 255; also address trace and start-while-busy.
        clear_weights();
        fill_neuron(7, 32'h0001_0001, 32'h0001_0001);
        fill_pixels(8'd255, 8'd255, 8'd255, 8'd255);
        do_start(1, 4'd7, 36'sd199920, c0);
        for (int i = 0; i < 4; i++) begin
            chk("trace_weight_address", weight_address, i);
            chk("trace_pixel_address", pixel_address, i >> 1);
            chk("trace_r_enable", r_enable, 1);
            if (i == 1) start = 1'b1;
            if (i == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        wait_until(c0 + 393);
        chk("drain_r_enable", r_enable, 0);
        chk("drain_busy", busy, 1);
        wait_until(c0 + 395);
        chk("n1_weight_address", weight_address, 392);
        chk("n1_pixel_address", pixel_address, 0);
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", done, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_result", result, 0);
        chk("clr_max_score", max_score, 0);

        // Tie between neurons 2 and 5: lower index wins.
        clear_weights();
        fill_neuron(2, 32'h0001_0001, 32'h0001_0001);
        fill_neuron(5, 32'h0001_0001, 32'h0001_0001);
        fill_pixels(8'd1, 8'd1, 8'd1, 8'd1);
        do_start(1, 4'd2, 36'sd784, c0);
        wait_done();

        // Lane/parity check, restarted straight from DONE.
        clear_weights();
        fill_neuron(3, 32'h0000_0001, 32'h0000_0000);
        fill_neuron(4, 32'h0001_0000, 32'h0000_0000);
        fill_neuron(8, 32'h0000_0000, 32'hFFFF_0000);
        fill_pixels(8'd1, 8'd10, 8'd100, 8'd50);
        do_start(1, 4'd4, 36'sd1960, c0);
        chk("restart_clears_done", done, 0);
        wait_done();

        // Every neuron most-negative: signed path, neuron 0 wins.
        for (int i = 0; i < 4096; i++) wmem[i] = 32'h8000_8000;
        fill_pixels(8'd255, 8'd255, 8'd255, 8'd255);
        do_start(1, 4'd0, -36'sd6550978560, c0);
        wait_done();

        // Abort mid-run with clear, then restart on neuron-7 data.
        clear_weights();
        fill_neuron(7, 32'h0001_0001, 32'h0001_0001);
        do_start(0, 4'd0, 36'sd0, c0);
        wait_until(c0 + 1000);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_r_enable", r_enable, 0);
        chk("abort_done", done, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_done_later", done, 0);
        do_start(1, 4'd7, 36'sd199920, c0);
        wait_done();

        // Start and clear together: clear wins.
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        start = 1'b0;
        chk("start_clear_busy", busy, 0);
        chk("start_clear_done", done, 0);

        // Reset in the middle of a run.
        do_start(0, 4'd0, 36'sd0, c0);
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_r_enable", r_enable, 0);
        chk("midrst_weight_address", weight_address, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_after", busy, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
